// File: rtl/learn_mode_packed_mem.sv
// Packed learn-mode bit store: WORD_WIDTH synapse bits per RAM word, served through a
// one-word read cache, with bit read-modify-write, full-word writes and a whole-memory clear.
module learn_mode_packed_mem #(
  parameter int unsigned NUM_NURNS          = 256,
  parameter int unsigned NUM_AXONS          = 256,
  parameter int unsigned NURN_CNT_BIT_WIDTH = 8,
  parameter int unsigned AXON_CNT_BIT_WIDTH = 8,
  parameter int unsigned WORD_WIDTH         = 4
) (
  input  logic                                          clk_i,
  input  logic                                          rst_i,
  input  logic                                          rd_req_i,
  input  logic [NURN_CNT_BIT_WIDTH+AXON_CNT_BIT_WIDTH-1:0] rd_addr_i,
  output logic                                          rd_ready_o,
  output logic                                          rd_valid_o,
  output logic                                          rd_bit_o,
  output logic                                          rd_hit_o,
  input  logic                                          wr_req_i,
  input  logic                                          wr_word_i,
  input  logic [NURN_CNT_BIT_WIDTH+AXON_CNT_BIT_WIDTH-1:0] wr_addr_i,
  input  logic [WORD_WIDTH-1:0]                         wr_data_i,
  output logic                                          wr_ready_o,
  input  logic                                          clr_req_i,
  output logic                                          busy_o,
  output logic                                          done_o
);

  localparam int unsigned ADDR_W = NURN_CNT_BIT_WIDTH + AXON_CNT_BIT_WIDTH;
  localparam int unsigned SEL_W  = $clog2(WORD_WIDTH);
  localparam int unsigned SEL_I  = (SEL_W == 0) ? 1 : SEL_W;
  localparam int unsigned DEPTH  = (NUM_NURNS * NUM_AXONS) / WORD_WIDTH;
  localparam int unsigned AW     = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, RMW, CLEAR} state_t;

  state_t                state;
  logic [WORD_WIDTH-1:0] mem [DEPTH];
  logic [WORD_WIDTH-1:0] ram_q;
  logic                  ram_en, ram_we;
  logic [AW-1:0]         ram_addr;
  logic [WORD_WIDTH-1:0] ram_wdata;

  logic [WORD_WIDTH-1:0] cache_word;
  logic [AW-1:0]         cache_tag;
  logic                  cache_valid;
  logic                  fill_pend;
  logic [AW-1:0]         fill_tag;

  logic [WORD_WIDTH-1:0] eff_word;
  logic [AW-1:0]         eff_tag;
  logic                  eff_valid;

  logic                  rd_from_ram;
  logic [SEL_I-1:0]      rd_sel_q;
  logic                  rd_bit_q;

  logic [AW-1:0]         rmw_addr;
  logic [SEL_I-1:0]      rmw_sel;
  logic                  rmw_bit;
  logic [WORD_WIDTH-1:0] rmw_word;
  logic                  rmw_from_ram;
  logic [WORD_WIDTH-1:0] rmw_base, rmw_mask, rmw_merged;

  logic [AW:0]           clr_cnt;

  logic                  idle, rd_hit, wr_hit;
  logic [AW-1:0]         rd_wa, wr_wa;
  logic [SEL_I-1:0]      rd_sel, wr_sel;

  function automatic logic [AW-1:0] word_of(input logic [ADDR_W-1:0] a);
    return AW'(a >> SEL_W);
  endfunction

  function automatic logic [SEL_I-1:0] sel_of(input logic [ADDR_W-1:0] a);
    return SEL_I'(a & ADDR_W'(WORD_WIDTH - 1));
  endfunction

  // A word still arriving from RAM after a miss already counts as the cached word.
  always_comb begin
    eff_word  = fill_pend ? ram_q : cache_word;
    eff_tag   = fill_pend ? fill_tag : cache_tag;
    eff_valid = fill_pend | cache_valid;
    idle      = (state == IDLE);
    rd_wa     = word_of(rd_addr_i);
    wr_wa     = word_of(wr_addr_i);
    rd_sel    = sel_of(rd_addr_i);
    wr_sel    = sel_of(wr_addr_i);
    rd_hit    = eff_valid && (eff_tag == rd_wa);
    wr_hit    = eff_valid && (eff_tag == wr_wa);
    rd_ready_o = idle & ~clr_req_i & ~rst_i;
    wr_ready_o = idle & ~clr_req_i & ~rd_req_i & ~rst_i;
    rmw_base   = rmw_from_ram ? ram_q : rmw_word;
    rmw_mask   = WORD_WIDTH'(1) << rmw_sel;
    rmw_merged = (rmw_base & ~rmw_mask) | (rmw_bit ? rmw_mask : '0);
    rd_bit_o   = rd_valid_o & (rd_from_ram ? ram_q[rd_sel_q] : rd_bit_q);
  end

  // Single RAM port control; reads, writes and clear never collide in one cycle.
  always_comb begin
    ram_en    = 1'b0;
    ram_we    = 1'b0;
    ram_addr  = '0;
    ram_wdata = '0;
    if (!rst_i) begin
      case (state)
        IDLE: begin
          if (clr_req_i) begin
            ram_en = 1'b0;
          end else if (rd_req_i) begin
            ram_en   = ~rd_hit;
            ram_addr = rd_wa;
          end else if (wr_req_i) begin
            ram_addr = wr_wa;
            if (wr_word_i) begin
              ram_en    = 1'b1;
              ram_we    = 1'b1;
              ram_wdata = wr_data_i;
            end else begin
              ram_en = ~wr_hit;
            end
          end
        end
        RMW: begin
          ram_en    = 1'b1;
          ram_we    = 1'b1;
          ram_addr  = rmw_addr;
          ram_wdata = rmw_merged;
        end
        CLEAR: begin
          ram_en   = 1'b1;
          ram_we   = 1'b1;
          ram_addr = clr_cnt[AW-1:0];
        end
        default: ram_en = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (ram_en) begin
      if (ram_we) mem[ram_addr] <= ram_wdata;
      else        ram_q         <= mem[ram_addr];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state       <= IDLE;
      cache_valid <= 1'b0;
      fill_pend   <= 1'b0;
      rd_valid_o  <= 1'b0;
      rd_hit_o    <= 1'b0;
      rd_from_ram <= 1'b0;
      rd_bit_q    <= 1'b0;
      done_o      <= 1'b0;
      busy_o      <= 1'b0;
      clr_cnt     <= '0;
    end else begin
      rd_valid_o  <= 1'b0;
      rd_hit_o    <= 1'b0;
      rd_from_ram <= 1'b0;
      done_o      <= 1'b0;
      fill_pend   <= 1'b0;
      if (fill_pend) begin
        cache_word  <= ram_q;
        cache_tag   <= fill_tag;
        cache_valid <= 1'b1;
      end
      // Write data overrides a same-cycle fill of the same word.
      if (ram_we && eff_valid && (ram_addr == eff_tag)) cache_word <= ram_wdata;
      case (state)
        IDLE: begin
          if (clr_req_i) begin
            state       <= CLEAR;
            busy_o      <= 1'b1;
            clr_cnt     <= '0;
            cache_valid <= 1'b0;
          end else if (rd_req_i) begin
            rd_valid_o  <= 1'b1;
            rd_hit_o    <= rd_hit;
            rd_sel_q    <= rd_sel;
            rd_bit_q    <= eff_word[rd_sel];
            rd_from_ram <= ~rd_hit;
            if (!rd_hit) begin
              fill_pend <= 1'b1;
              fill_tag  <= rd_wa;
            end
          end else if (wr_req_i) begin
            if (wr_word_i) begin
              done_o <= 1'b1;
            end else begin
              state        <= RMW;
              busy_o       <= 1'b1;
              rmw_addr     <= wr_wa;
              rmw_sel      <= wr_sel;
              rmw_bit      <= wr_data_i[0];
              rmw_word     <= eff_word;
              rmw_from_ram <= ~wr_hit;
            end
          end
        end
        RMW: begin
          state  <= IDLE;
          busy_o <= 1'b0;
          done_o <= 1'b1;
        end
        CLEAR: begin
          if (clr_cnt == (AW+1)'(DEPTH - 1)) begin
            state  <= IDLE;
            busy_o <= 1'b0;
            done_o <= 1'b1;
          end else begin
            clr_cnt <= clr_cnt + (AW+1)'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_learn_mode_packed_mem.sv
// Directed bench for learn_mode_packed_mem: default geometry plus a 64-axon, 16-bit-word instance.
module tb_learn_mode_packed_mem;

  localparam int DEPTH_A = 16384;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  logic        rd_req, rd_ready, rd_valid, rd_bit, rd_hit;
  logic [15:0] rd_addr, wr_addr;
  logic        wr_req, wr_word, wr_ready, clr_req, busy, done;
  logic [3:0]  wr_data;

  logic        b_rd_req, b_rd_ready, b_rd_valid, b_rd_bit, b_rd_hit;
  logic [13:0] b_rd_addr, b_wr_addr;
  logic        b_wr_req, b_wr_word, b_wr_ready, b_clr_req, b_busy, b_done;
  logic [15:0] b_wr_data;

  learn_mode_packed_mem dut_a (
    .clk_i(clk), .rst_i(rst),
    .rd_req_i(rd_req), .rd_addr_i(rd_addr), .rd_ready_o(rd_ready),
    .rd_valid_o(rd_valid), .rd_bit_o(rd_bit), .rd_hit_o(rd_hit),
    .wr_req_i(wr_req), .wr_word_i(wr_word), .wr_addr_i(wr_addr),
    .wr_data_i(wr_data), .wr_ready_o(wr_ready),
    .clr_req_i(clr_req), .busy_o(busy), .done_o(done)
  );

  learn_mode_packed_mem #(
    .NUM_NURNS(256), .NUM_AXONS(64), .NURN_CNT_BIT_WIDTH(8),
    .AXON_CNT_BIT_WIDTH(6), .WORD_WIDTH(16)
  ) dut_b (
    .clk_i(clk), .rst_i(rst),
    .rd_req_i(b_rd_req), .rd_addr_i(b_rd_addr), .rd_ready_o(b_rd_ready),
    .rd_valid_o(b_rd_valid), .rd_bit_o(b_rd_bit), .rd_hit_o(b_rd_hit),
    .wr_req_i(b_wr_req), .wr_word_i(b_wr_word), .wr_addr_i(b_wr_addr),
    .wr_data_i(b_wr_data), .wr_ready_o(b_wr_ready),
    .clr_req_i(b_clr_req), .busy_o(b_busy), .done_o(b_done)
  );

  int compared = 0;
  int mismatched = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {logic bitv; logic hit; int due;} exp_t;
  exp_t qa[$];
  exp_t qb[$];

  bit          mdl [65536];
  bit          mc_valid;
  logic [13:0] mc_tag;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one read of instance A and queue its expected bit/hit/arrival cycle.
  task automatic rd(input logic [15:0] addr);
    logic hit;
    rd_req  = 1'b1;
    rd_addr = addr;
    #1;
    check("rd_ready", rd_ready, 1);
    hit = mc_valid && (mc_tag == addr[15:2]);
    qa.push_back('{mdl[addr], hit, cyc + 1});
    mc_valid = 1'b1;
    mc_tag   = addr[15:2];
    tick();
  endtask

  task automatic ww(input logic [15:0] addr, input logic [3:0] data);
    wr_req  = 1'b1;
    wr_word = 1'b1;
    wr_addr = addr;
    wr_data = data;
    #1;
    check("ww_ready", wr_ready, 1);
    for (int i = 0; i < 4; i++) mdl[{addr[15:2], 2'(i)}] = data[i];
    tick();
    wr_req = 1'b0;
    check("ww_done", done, 1);
  endtask

  task automatic bw(input logic [15:0] addr, input logic b);
    wr_req  = 1'b1;
    wr_word = 1'b0;
    wr_addr = addr;
    wr_data = {3'b000, b};
    #1;
    check("bw_ready", wr_ready, 1);
    mdl[addr] = b;
    tick();
    wr_req = 1'b0;
    check("bw_rmw_busy", busy, 1);
    check("bw_rmw_done", done, 0);
    tick();
    check("bw_done", done, 1);
    check("bw_busy_end", busy, 0);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rd_valid === 1'b1) begin
      if (qa.size() == 0) check("a_rd_unexpected", 1, 0);
      else begin
        e = qa.pop_front();
        check("a_rd_bit", rd_bit, e.bitv);
        check("a_rd_hit", rd_hit, e.hit);
        check("a_rd_cycle", cyc, e.due);
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (b_rd_valid === 1'b1) begin
      if (qb.size() == 0) check("b_rd_unexpected", 1, 0);
      else begin
        e = qb.pop_front();
        check("b_rd_bit", b_rd_bit, e.bitv);
        check("b_rd_hit", b_rd_hit, e.hit);
        check("b_rd_cycle", cyc, e.due);
      end
    end
  end

  initial begin
    logic [15:0] pat [4];
    int   cnt;
    bit   saw_done;
    pat[0] = 16'hA5C3; pat[1] = 16'h0F0F; pat[2] = 16'h1234; pat[3] = 16'hFFFE;
    rst = 1'b1;
    rd_req = 0; rd_addr = '0; wr_req = 0; wr_word = 0; wr_addr = '0; wr_data = '0; clr_req = 0;
    b_rd_req = 0; b_rd_addr = '0; b_wr_req = 0; b_wr_word = 0; b_wr_addr = '0; b_wr_data = '0;
    b_clr_req = 0;
    mc_valid = 1'b0;
    mc_tag   = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_rd_valid", rd_valid, 0);
    check("rst_rd_bit", rd_bit, 0);
    check("rst_rd_hit", rd_hit, 0);
    check("rst_done", done, 0);
    check("rst_busy", busy, 0);
    check("rst_rd_ready", rd_ready, 0);
    check("rst_wr_ready", wr_ready, 0);
    rst = 1'b0;
    #1;
    check("post_rst_rd_ready", rd_ready, 1);
    check("post_rst_wr_ready", wr_ready, 1);
    check("post_rst_b_rd_ready", b_rd_ready, 1);

    // Word write then bit reads across the word: first miss, then hits.
    ww({8'd3, 8'd8}, 4'b1010);
    for (int a = 8; a < 12; a++) rd({8'd3, 8'(a)});
    rd_req = 1'b0;

    // Bit write through the RAM path, then through the cached-word path.
    ww({8'd3, 8'd12}, 4'b0000);
    ww({8'd3, 8'd8}, 4'b0000);
    rd({8'd3, 8'd12});
    rd_req = 1'b0;
    bw({8'd3, 8'd9}, 1'b1);
    rd({8'd3, 8'd9});
    rd({8'd3, 8'd8});
    rd({8'd3, 8'd10});
    rd_req = 1'b0;
    bw({8'd3, 8'd10}, 1'b1);
    rd({8'd3, 8'd10});
    rd({8'd3, 8'd11});
    rd_req = 1'b0;

    // Read and write requested together: reads win for three cycles.
    wr_req = 1'b1; wr_word = 1'b1; wr_addr = {8'd5, 8'd0}; wr_data = 4'hF;
    for (int a = 8; a < 11; a++) begin
      rd_req = 1'b1;
      #1;
      check("both_wr_ready", wr_ready, 0);
      rd({8'd3, 8'(a)});
    end
    rd_req = 1'b0;
    #1;
    check("both_wr_ready_4th", wr_ready, 1);
    for (int i = 0; i < 4; i++) mdl[{8'd5, 8'(i)}] = 1'b1;
    tick();
    wr_req = 1'b0;
    check("both_wr_done", done, 1);
    rd({8'd5, 8'd1});
    rd_req = 1'b0;

    // Fill everything with ones, then clear.
    wr_req = 1'b1; wr_word = 1'b1; wr_data = 4'hF;
    for (int w = 0; w < DEPTH_A; w++) begin
      wr_addr = 16'(w << 2);
      tick();
    end
    wr_req = 1'b0;
    for (int i = 0; i < 65536; i++) mdl[i] = 1'b1;
    rd(16'h0000);
    rd_req  = 1'b0;
    clr_req = 1'b1;
    #1;
    check("clr_rd_ready", rd_ready, 0);
    check("clr_wr_ready", wr_ready, 0);
    tick();
    clr_req  = 1'b0;
    mc_valid = 1'b0;
    for (int i = 0; i < 65536; i++) mdl[i] = 1'b0;
    cnt      = 0;
    saw_done = 1'b0;
    rd_req   = 1'b1;
    while (busy === 1'b1 && cnt < 20000) begin
      if (cnt == 5) begin
        check("clear_rd_ready_low", rd_ready, 0);
        rd_req = 1'b0;
      end
      if (done === 1'b1) saw_done = 1'b1;
      cnt++;
      tick();
    end
    rd_req = 1'b0;
    check("clear_busy_cycles", cnt, DEPTH_A);
    check("clear_early_done", saw_done, 0);
    check("clear_done", done, 1);
    rd(16'h0000);
    rd(16'((DEPTH_A / 2) << 2));
    rd(16'hFFFC);
    rd_req = 1'b0;

    // Reset in the middle of a clear.
    wr_req = 1'b1; wr_word = 1'b1; wr_data = 4'hF;
    for (int w = 0; w < 256; w++) begin
      wr_addr = 16'(w << 2);
      tick();
    end
    wr_req = 1'b0;
    for (int i = 0; i < 1024; i++) mdl[i] = 1'b1;
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    repeat (99) tick();
    check("abort_busy", busy, 1);
    rst = 1'b1;
    tick();
    check("abort_done_in_rst", done, 0);
    rst = 1'b0;
    #1;
    check("abort_done", done, 0);
    check("abort_busy_low", busy, 0);
    check("abort_rd_ready", rd_ready, 1);
    mc_valid = 1'b0;
    for (int i = 0; i < 99 * 4; i++) mdl[i] = 1'b0;
    rd(16'(50 << 2));
    rd(16'(200 << 2));
    rd_req = 1'b0;

    // Second geometry: 64 axons, 16-bit words, neuron 255.
    b_wr_req = 1'b1; b_wr_word = 1'b1;
    for (int w = 0; w < 4; w++) begin
      b_wr_addr = {8'd255, 6'(w * 16)};
      b_wr_data = pat[w];
      #1;
      check("b_ww_ready", b_wr_ready, 1);
      tick();
      check("b_ww_done", b_done, 1);
    end
    b_wr_req = 1'b0;
    for (int a = 0; a < 64; a++) begin
      logic [15:0] p;
      p = pat[a / 16];
      b_rd_req  = 1'b1;
      b_rd_addr = {8'd255, 6'(a)};
      qb.push_back('{p[a % 16], (a % 16) != 0, cyc + 1});
      tick();
    end
    b_rd_req = 1'b0;

    repeat (3) tick();
    check("a_queue_drained", qa.size(), 0);
    check("b_queue_drained", qb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
